// File: rtl/iob_cfg_loader.sv
// Shadow config store for a chain of I/O blocks plus the sequencer that shifts the
// image out serially (SEN/SDO) and then pulses UPDATE so all blocks switch together.
module iob_cfg_loader #(
    parameter int NUM_IOB = 16,
    parameter int CFG_W   = 3,
    localparam int AW     = ($clog2(NUM_IOB) > 1) ? $clog2(NUM_IOB) : 1
) (
    input  logic             IOCLK,
    input  logic             RSTN,
    input  logic             CFG_WE,
    input  logic [AW-1:0]    CFG_ADDR,
    input  logic [CFG_W-1:0] CFG_DATA,
    output logic [CFG_W-1:0] CFG_RDATA,
    input  logic             START,
    output logic             BUSY,
    output logic             DONE,
    output logic             WR_ERR,
    output logic             SEN,
    output logic             SDO,
    output logic             UPDATE
);

    localparam int L  = NUM_IOB * CFG_W;
    localparam int CW = ($clog2(L) > 0) ? $clog2(L) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, UPDT} state_t;

    state_t           state_q, state_d;
    logic [CFG_W-1:0] shadow_q [NUM_IOB];
    logic [CFG_W-1:0] shadow_d [NUM_IOB];
    logic [L-1:0]     sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             wr_err_q, wr_err_d;
    logic             sen_q, sen_d;
    logic             sdo_q, sdo_d;
    logic             update_q, update_d;

    logic [L-1:0]     snap;
    logic             addr_ok;
    logic             we_ok;

    // Bit 0 of the snapshot leaves first: highest block, MSB first within a block.
    always_comb begin
        snap = '0;
        for (int b = 0; b < NUM_IOB; b++) begin
            for (int j = 0; j < CFG_W; j++) begin
                snap[(NUM_IOB-1-b)*CFG_W + (CFG_W-1-j)] = shadow_q[b][j];
            end
        end
    end

    always_comb begin
        addr_ok   = (int'(CFG_ADDR) < NUM_IOB);
        CFG_RDATA = addr_ok ? shadow_q[CFG_ADDR] : '0;
        we_ok     = CFG_WE && (state_q == IDLE) && addr_ok;
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        wr_err_d = wr_err_q;
        sen_d    = sen_q;
        sdo_d    = sdo_q;
        update_d = 1'b0;

        if (we_ok) begin
            shadow_d[CFG_ADDR] = CFG_DATA;
        end

        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d  = SHIFT;
                    sreg_d   = snap >> 1;
                    sdo_d    = snap[0];
                    sen_d    = 1'b1;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    wr_err_d = 1'b0;
                end
            end
            SHIFT: begin
                if (cnt_q == CW'(L-1)) begin
                    state_d  = UPDT;
                    sen_d    = 1'b0;
                    sdo_d    = 1'b0;
                    update_d = 1'b1;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    sdo_d  = sreg_q[0];
                    sreg_d = sreg_q >> 1;
                end
            end
            UPDT: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // A rejected write in the same cycle as START still leaves the error flagged.
        if (CFG_WE && !we_ok) begin
            wr_err_d = 1'b1;
        end
    end

    always_ff @(posedge IOCLK) begin
        if (!RSTN) begin
            state_q  <= IDLE;
            shadow_q <= '{default: '0};
            sreg_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wr_err_q <= 1'b0;
            sen_q    <= 1'b0;
            sdo_q    <= 1'b0;
            update_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            sreg_q   <= sreg_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wr_err_q <= wr_err_d;
            sen_q    <= sen_d;
            sdo_q    <= sdo_d;
            update_q <= update_d;
        end
    end

    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign WR_ERR = wr_err_q;
    assign SEN    = sen_q;
    assign SDO    = sdo_q;
    assign UPDATE = update_q;

endmodule

// File: tb/tb_iob_cfg_loader.sv
// Directed bench for iob_cfg_loader: a 4-block instance for load sequencing and a
// 6-block instance for out-of-range address handling.
module tb_iob_cfg_loader;

    logic       clk = 1'b0;
    logic       rstn;

    logic       we4, start4, busy4, done4, err4, sen4, sdo4, upd4;
    logic [1:0] addr4;
    logic [2:0] data4, rdata4;

    logic       we6, start6, busy6, done6, err6, sen6, sdo6, upd6;
    logic [2:0] addr6;
    logic [2:0] data6, rdata6;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    iob_cfg_loader #(.NUM_IOB(4), .CFG_W(3)) dut4 (
        .IOCLK(clk), .RSTN(rstn), .CFG_WE(we4), .CFG_ADDR(addr4), .CFG_DATA(data4),
        .CFG_RDATA(rdata4), .START(start4), .BUSY(busy4), .DONE(done4), .WR_ERR(err4),
        .SEN(sen4), .SDO(sdo4), .UPDATE(upd4)
    );

    iob_cfg_loader #(.NUM_IOB(6), .CFG_W(3)) dut6 (
        .IOCLK(clk), .RSTN(rstn), .CFG_WE(we6), .CFG_ADDR(addr6), .CFG_DATA(data6),
        .CFG_RDATA(rdata6), .START(start6), .BUSY(busy6), .DONE(done6), .WR_ERR(err6),
        .SEN(sen6), .SDO(sdo6), .UPDATE(upd6)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wr4(input logic [1:0] a, input logic [2:0] d);
        we4 = 1'b1; addr4 = a; data4 = d;
        @(negedge clk);
        we4 = 1'b0;
    endtask

    task automatic rd4(input string tag, input logic [1:0] a, input logic [2:0] exp);
        addr4 = a;
        #1;
        chk(tag, 32'(rdata4), 32'(exp));
    endtask

    task automatic go4();
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
    endtask

    // Entered in the first SEN cycle; exp bit i is the i-th serial bit.
    task automatic shift4(input logic [11:0] exp, input bit inj, input bit again);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("sen[%0d]", i), 32'(sen4), 32'd1);
            chk($sformatf("sdo[%0d]", i), 32'(sdo4), 32'(exp[i]));
            chk($sformatf("busy[%0d]", i), 32'(busy4), 32'd1);
            chk($sformatf("upd[%0d]", i), 32'(upd4), 32'd0);
            if (inj && i == 5) chk("wr_err_busy", 32'(err4), 32'd1);
            if (inj && i == 2) begin
                we4 = 1'b1; addr4 = 2'd0; data4 = 3'b110;
            end else begin
                we4 = 1'b0;
            end
            @(negedge clk);
        end
        chk("upd_pulse", 32'(upd4), 32'd1);
        chk("upd_sen", 32'(sen4), 32'd0);
        chk("upd_sdo", 32'(sdo4), 32'd0);
        chk("upd_busy", 32'(busy4), 32'd1);
        chk("upd_done", 32'(done4), 32'd0);
        @(negedge clk);
        chk("done_pulse", 32'(done4), 32'd1);
        chk("done_busy", 32'(busy4), 32'd0);
        chk("done_upd", 32'(upd4), 32'd0);
        if (again) start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        if (!again) chk("done_clear", 32'(done4), 32'd0);
    endtask

    initial begin
        logic upd_seen;
        rstn = 1'b0;
        we4 = 0; start4 = 0; addr4 = 0; data4 = 0;
        we6 = 0; start6 = 0; addr6 = 0; data6 = 0;

        // Reset held two cycles
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 32'({busy4, busy6}), 32'd0);
        chk("rst_done", 32'({done4, done6}), 32'd0);
        chk("rst_err", 32'({err4, err6}), 32'd0);
        chk("rst_sen", 32'({sen4, sen6}), 32'd0);
        chk("rst_sdo", 32'({sdo4, sdo6}), 32'd0);
        chk("rst_upd", 32'({upd4, upd6}), 32'd0);
        for (int a = 0; a < 4; a++) rd4($sformatf("rst_rd4[%0d]", a), 2'(a), 3'b000);
        for (int a = 0; a < 8; a++) begin
            addr6 = 3'(a);
            #1;
            chk($sformatf("rst_rd6[%0d]", a), 32'(rdata6), 32'd0);
        end
        rstn = 1'b1;
        @(negedge clk);

        // Image A and readback
        wr4(2'd3, 3'b101);
        wr4(2'd2, 3'b010);
        wr4(2'd1, 3'b111);
        wr4(2'd0, 3'b001);
        rd4("rd_a3", 2'd3, 3'b101);
        rd4("rd_a2", 2'd2, 3'b010);
        rd4("rd_a1", 2'd1, 3'b111);
        rd4("rd_a0", 2'd0, 3'b001);
        chk("err_idle", 32'(err4), 32'd0);

        // Load A with a write attempted while busy
        go4();
        shift4(12'h9D5, 1'b1, 1'b0);
        rd4("busy_wr_ignored", 2'd0, 3'b001);
        chk("err_sticky", 32'(err4), 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("err_held", 32'(err4), 32'd1);

        // Image B: a3=000 a2=010 a1=111 a0=110, then back-to-back repeat
        wr4(2'd0, 3'b110);
        wr4(2'd3, 3'b000);
        rd4("rd_b0", 2'd0, 3'b110);
        chk("err_before_start", 32'(err4), 32'd1);
        go4();
        chk("err_cleared", 32'(err4), 32'd0);
        shift4(12'h7D0, 1'b0, 1'b1);
        shift4(12'h7D0, 1'b0, 1'b0);

        // Write coinciding with START: lands in shadow, not in the image
        wr4(2'd0, 3'b000);
        we4 = 1'b1; addr4 = 2'd0; data4 = 3'b011; start4 = 1'b1;
        @(negedge clk);
        we4 = 1'b0; start4 = 1'b0;
        shift4(12'h1D0, 1'b0, 1'b0);
        rd4("same_cycle_wr", 2'd0, 3'b011);
        chk("same_cycle_err", 32'(err4), 32'd0);

        // Out-of-range write on the 6-block instance
        we6 = 1'b1; addr6 = 3'd5; data6 = 3'b011;
        @(negedge clk);
        we6 = 1'b1; addr6 = 3'd7; data6 = 3'b101;
        @(negedge clk);
        we6 = 1'b0;
        chk("oor_err", 32'(err6), 32'd1);
        addr6 = 3'd7; #1;
        chk("oor_rd7", 32'(rdata6), 32'd0);
        addr6 = 3'd5; #1;
        chk("rd6_a5", 32'(rdata6), 32'b011);

        // Reset in the middle of a shift
        go4();
        for (int i = 0; i < 4; i++) @(negedge clk);
        chk("pre_rst_sen", 32'(sen4), 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        chk("mid_rst_sen", 32'(sen4), 32'd0);
        chk("mid_rst_busy", 32'(busy4), 32'd0);
        chk("mid_rst_upd", 32'(upd4), 32'd0);
        rd4("mid_rst_shadow", 2'd1, 3'b000);
        rstn = 1'b1;
        upd_seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (upd4 || sen4 || busy4) upd_seen = 1'b1;
        end
        chk("no_upd_after_abort", 32'(upd_seen), 32'd0);
        chk("err6_reset", 32'(err6), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
